// File: rtl/bus_pkg.sv
// Shared bus slave definitions: response codes, the slave FSM state type and
// the largest supported wait-state count.
package bus_pkg;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam int MAX_WAIT = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LAST,
    ERR1,
    ERR2
  } slv_state_e;

endpackage

// File: rtl/slave_mem_array.sv
// Word storage for the SRAM slave: one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module slave_mem_array #(
  parameter int DWidth = 32,
  parameter int Depth  = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [DWidth-1:0]        wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [DWidth-1:0]        rdata_o
);

  logic [DWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM bus slave with a pipelined address/data phase,
// programmable OKAY wait states and a two-cycle ERROR response.
module bus_sram_slave
  import bus_pkg::*;
#(
  parameter int DWidth     = 32,
  parameter int Depth      = 1024,
  parameter int WaitCycles = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sel_i,
  input  logic              trans_i,
  input  logic              write_i,
  input  logic [DWidth-1:0] addr_i,
  input  logic [DWidth-1:0] wdata_i,
  input  logic              ready_i,
  output logic [DWidth-1:0] rdata_o,
  output logic              resp_o,
  output logic              readyout_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CntInit = CW'((WaitCycles == 0) ? 0 : WaitCycles - 1);

  slv_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [AW-1:0]     idx_q, idx_d;

  logic              accept;
  logic              addr_err;
  logic              mem_we;
  logic [DWidth-1:0] mem_rdata;

  assign addr_err = (addr_i[1:0] != 2'b00) || (addr_i[DWidth-1:AW+2] != '0);
  assign accept   = sel_i && trans_i && ready_i &&
                    ((state_q == IDLE) || (state_q == LAST) || (state_q == ERR2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, LAST, ERR2: begin
        if (accept) begin
          write_d = write_i;
          idx_d   = addr_i[AW+1:2];
          if (addr_err) begin
            state_d = ERR1;
          end else if (WaitCycles == 0) begin
            state_d = LAST;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    readyout_o = 1'b1;
    resp_o     = RESP_OKAY;
    rdata_o    = '0;
    unique case (state_q)
      WAIT: readyout_o = 1'b0;
      LAST: begin
        if (!write_q) begin
          rdata_o = mem_rdata;
        end
      end
      ERR1: begin
        readyout_o = 1'b0;
        resp_o     = RESP_ERROR;
      end
      ERR2:    resp_o = RESP_ERROR;
      default: ;
    endcase
  end

  // A reset edge that coincides with LAST must not commit the pending write.
  assign mem_we = rst_ni && (state_q == LAST) && write_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
    end
  end

  slave_mem_array #(
    .DWidth(DWidth),
    .Depth (Depth)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(idx_q),
    .wdata_i(wdata_i),
    .raddr_i(idx_q),
    .rdata_o(mem_rdata)
  );

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: one instance with two wait states and one
// with zero wait states, sharing the master-side stimulus.
module tb_bus_sram_slave;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        trans;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata2, rdata0;
  logic        resp2, resp0;
  logic        ready2, ready0;

  bit          use_zero;
  logic [31:0] obs_rdata;
  logic        obs_resp;
  logic        obs_ready;

  int assertions;
  int failures;

  bus_sram_slave #(.DWidth(32), .Depth(16), .WaitCycles(2)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sel_i     (sel),
    .trans_i   (trans),
    .write_i   (write),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .ready_i   (ready2),
    .rdata_o   (rdata2),
    .resp_o    (resp2),
    .readyout_o(ready2)
  );

  bus_sram_slave #(.DWidth(32), .Depth(16), .WaitCycles(0)) dut_zero (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sel_i     (sel),
    .trans_i   (trans),
    .write_i   (write),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .ready_i   (ready0),
    .rdata_o   (rdata0),
    .resp_o    (resp0),
    .readyout_o(ready0)
  );

  assign obs_rdata = use_zero ? rdata0 : rdata2;
  assign obs_resp  = use_zero ? resp0  : resp2;
  assign obs_ready = use_zero ? ready0 : ready2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of master signals, then move to the next falling edge.
  task automatic applyStimulus(input logic s, input logic t, input logic w,
                               input logic [31:0] a, input logic [31:0] d);
    sel   = s;
    trans = t;
    write = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Single non-overlapped transfer from IDLE; nCyc is the expected data-phase length.
  task automatic doPhase(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int nCyc, input logic expErr,
                         input logic [31:0] expRd);
    applyStimulus(1'b1, 1'b1, wr, a, d);
    for (int i = 0; i < nCyc; i++) begin
      checkOutput({tag, "_ready"}, {31'b0, obs_ready}, {31'b0, (i == nCyc - 1)});
      checkOutput({tag, "_resp"}, {31'b0, obs_resp}, {31'b0, expErr});
      checkOutput({tag, "_rdata"}, obs_rdata,
                  ((i == nCyc - 1) && !wr && !expErr) ? expRd : 32'h0);
      applyStimulus(1'b1, 1'b0, wr, a, d);
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    use_zero   = 1'b0;
    rst_n      = 1'b0;
    sel        = 1'b0;
    trans      = 1'b0;
    write      = 1'b0;
    addr       = '0;
    wdata      = '0;
    @(negedge clk);

    // Reset held for two more edges.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_ready", {31'b0, ready2}, 32'h1);
    checkOutput("rst_resp", {31'b0, resp2}, 32'h0);
    checkOutput("rst_rdata", rdata2, 32'h0);
    checkOutput("rst_ready_w0", {31'b0, ready0}, 32'h1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Write then read back with two wait states.
    doPhase("w4", 1'b1, 32'h4, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    doPhase("r4", 1'b0, 32'h4, 32'h0, 3, 1'b0, 32'hDEADBEEF);

    // Read accepted in the write's LAST cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h8, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'h12345678);
    checkOutput("b2b_wlast_ready", {31'b0, ready2}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h8, 32'h12345678);
    checkOutput("b2b_rwait_ready", {31'b0, ready2}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    checkOutput("b2b_rwait2_ready", {31'b0, ready2}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    checkOutput("b2b_rlast_ready", {31'b0, ready2}, 32'h1);
    checkOutput("b2b_rdata", rdata2, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Error responses; errored writes must leave mem[0] alone.
    doPhase("w0", 1'b1, 32'h0, 32'h0BADF00D, 3, 1'b0, 32'h0);
    doPhase("r_mis", 1'b0, 32'h6, 32'h0, 2, 1'b1, 32'h0);
    doPhase("w_oor", 1'b1, 32'h40, 32'hFFFFFFFF, 2, 1'b1, 32'h0);
    doPhase("w_mis", 1'b1, 32'h1, 32'hFFFFFFFF, 2, 1'b1, 32'h0);
    doPhase("r_oor", 1'b0, 32'h8000_0044, 32'h0, 2, 1'b1, 32'h0);
    doPhase("r0", 1'b0, 32'h0, 32'h0, 3, 1'b0, 32'h0BADF00D);

    // Reset in the middle of a write's wait states drops the write.
    doPhase("wc1", 1'b1, 32'hC, 32'h11111111, 3, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hC, 32'h22222222);
    checkOutput("midrst_wait_ready", {31'b0, ready2}, 32'h0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 32'h22222222);
    checkOutput("midrst_ready", {31'b0, ready2}, 32'h1);
    checkOutput("midrst_resp", {31'b0, resp2}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("postrst_ready", {31'b0, ready2}, 32'h1);
    doPhase("rc", 1'b0, 32'hC, 32'h0, 3, 1'b0, 32'h11111111);

    // Unselected or IDLE transfers are never accepted.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 32'h0);
    checkOutput("nosel_ready", {31'b0, ready2}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 32'h0);
    checkOutput("nosel_ready2", {31'b0, ready2}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    checkOutput("notrans_ready", {31'b0, ready2}, 32'h1);
    checkOutput("notrans_rdata", rdata2, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    doPhase("r4_again", 1'b0, 32'h4, 32'h0, 3, 1'b0, 32'hDEADBEEF);

    // Zero-wait instance: let both slaves settle in IDLE first.
    use_zero = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    doPhase("z_w3c", 1'b1, 32'h3C, 32'hA5A5A5A5, 1, 1'b0, 32'h0);
    doPhase("z_r3c", 1'b0, 32'h3C, 32'h0, 1, 1'b0, 32'hA5A5A5A5);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h38, 32'h5A5A5A5A);
    checkOutput("z_b2b_wlast_ready", {31'b0, ready0}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h38, 32'h5A5A5A5A);
    checkOutput("z_b2b_rlast_ready", {31'b0, ready0}, 32'h1);
    checkOutput("z_b2b_rdata", rdata0, 32'h5A5A5A5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    doPhase("z_err", 1'b0, 32'h3E, 32'h0, 2, 1'b1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
